// File: rtl/slot_pkg.sv
// Shared state type, default parameters and a counter-width helper for the slot machine core.
package slot_pkg;

    typedef enum logic [1:0] {IDLE, RUNNING, STOPPING, DONE} slot_state_e;

    localparam int unsigned DefNumReels    = 3;
    localparam int unsigned DefSymW        = 3;
    localparam int unsigned DefTickDiv     = 10_000_000;
    localparam int unsigned DefDebounceCyc = 5_000_000;
    localparam int unsigned DefStopGap     = 100_000_000;

    // Width of a counter running 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/slot_debounce.sv
// Samples the active-low start/stop buttons once per DEBOUNCE_CYC cycles into held flags.
module slot_debounce
    import slot_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DefDebounceCyc
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic start_ni,
    input  logic stop_ni,
    output logic start_flag_o,
    output logic stop_flag_o
);

    localparam int unsigned     CntW   = cnt_width(DEBOUNCE_CYC);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYC - 1);

    logic [CntW-1:0] cnt_q;
    logic            start_flag_q;
    logic            stop_flag_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q        <= '0;
            start_flag_q <= 1'b0;
            stop_flag_q  <= 1'b0;
        end else if (cnt_q == CntMax) begin
            cnt_q        <= '0;
            start_flag_q <= ~start_ni;
            stop_flag_q  <= ~stop_ni;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign start_flag_o = start_flag_q;
    assign stop_flag_o  = stop_flag_q;

endmodule

// File: rtl/slot_core.sv
// Slot machine core: reel tick, spin FSM, staggered reel stops and optional win detect.
// Define SLOT_WIN_DETECT_EN to build the all-reels-equal win comparator; otherwise win is 0.
module slot_core
    import slot_pkg::*;
#(
    parameter int unsigned NUM_REELS    = DefNumReels,
    parameter int unsigned SYM_W        = DefSymW,
    parameter int unsigned TICK_DIV     = DefTickDiv,
    parameter int unsigned DEBOUNCE_CYC = DefDebounceCyc,
    parameter int unsigned STOP_GAP     = DefStopGap
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       stop,
    input  logic [NUM_REELS*SYM_W-1:0] lfsr_in,
    output logic [NUM_REELS*SYM_W-1:0] out,
    output logic [NUM_REELS-1:0]       enable,
    output logic                       busy,
    output logic                       done,
    output logic                       win
);

    localparam int unsigned      TickW   = cnt_width(TICK_DIV);
    localparam logic [TickW-1:0] TickMax = TickW'(TICK_DIV - 1);
    localparam int unsigned      StopMax = NUM_REELS * STOP_GAP;
    localparam int unsigned      StopW   = $clog2(StopMax + 1);
    localparam logic [StopW-1:0] StopSat = StopW'(StopMax);

    logic start_flag;
    logic stop_flag;

    slot_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_debounce (
        .clk_i       (clk),
        .reset_i     (reset),
        .start_ni    (start),
        .stop_ni     (stop),
        .start_flag_o(start_flag),
        .stop_flag_o (stop_flag)
    );

    logic [TickW-1:0] tick_cnt_q;
    logic             tick;

    always_ff @(posedge clk) begin
        if (reset || tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + 1'b1;
        end
    end

    assign tick = (tick_cnt_q == TickMax);

    slot_state_e           state_q;
    logic [NUM_REELS-1:0]  enable_q;
    logic [StopW-1:0]      stop_cnt_q;
    logic                  busy_q;
    logic                  done_q;
    logic [NUM_REELS-1:0]  gap_hit;

    // Reel i has reached its stop point once the counter passes (i+1)*STOP_GAP.
    always_comb begin
        gap_hit = '0;
        for (int unsigned i = 0; i < NUM_REELS; i++) begin
            gap_hit[i] = (32'(stop_cnt_q) >= (i + 1) * STOP_GAP);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            enable_q   <= '0;
            stop_cnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_flag) begin
                        state_q  <= RUNNING;
                        enable_q <= '1;
                        busy_q   <= 1'b1;
                    end
                end
                RUNNING: begin
                    if (stop_flag) begin
                        state_q    <= STOPPING;
                        stop_cnt_q <= '0;
                    end
                end
                STOPPING: begin
                    if (stop_cnt_q != StopSat) begin
                        stop_cnt_q <= stop_cnt_q + 1'b1;
                    end
                    enable_q <= enable_q & ~gap_hit;
                    if (gap_hit[NUM_REELS-1]) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q  <= IDLE;
                    enable_q <= '0;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b0;
                end
            endcase
        end
    end

    logic [NUM_REELS*SYM_W-1:0] out_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= '0;
        end else if (tick) begin
            for (int unsigned i = 0; i < NUM_REELS; i++) begin
                if (enable_q[i]) begin
                    out_q[i*SYM_W +: SYM_W] <= lfsr_in[i*SYM_W +: SYM_W];
                end
            end
        end
    end

`ifdef SLOT_WIN_DETECT_EN
    logic win_q;
    logic all_eq;

    always_comb begin
        all_eq = 1'b1;
        for (int unsigned i = 1; i < NUM_REELS; i++) begin
            if (out_q[i*SYM_W +: SYM_W] != out_q[SYM_W-1:0]) begin
                all_eq = 1'b0;
            end
        end
    end

    // Result is latched on the DONE cycle and held until the next spin begins.
    always_ff @(posedge clk) begin
        if (reset) begin
            win_q <= 1'b0;
        end else if (state_q == IDLE && start_flag) begin
            win_q <= 1'b0;
        end else if (state_q == DONE) begin
            win_q <= all_eq;
        end
    end

    assign win = win_q;
`else
    assign win = 1'b0;
`endif

    assign out    = out_q;
    assign enable = enable_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_slot_core.sv
// Directed bench for slot_core with short tick/debounce/stop-gap parameters.
module tb_slot_core;

    localparam int NR = 3;
    localparam int SW = 3;
`ifdef SLOT_WIN_DETECT_EN
    localparam bit WinEn = 1'b1;
`else
    localparam bit WinEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b1;
    logic          stop = 1'b1;
    logic [8:0]    lfsr_in = '0;
    logic [8:0]    out;
    logic [2:0]    enable;
    logic          busy;
    logic          done;
    logic          win;

    slot_core #(
        .NUM_REELS   (NR),
        .SYM_W       (SW),
        .TICK_DIV    (4),
        .DEBOUNCE_CYC(2),
        .STOP_GAP    (10)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .stop   (stop),
        .lfsr_in(lfsr_in),
        .out    (out),
        .enable (enable),
        .busy   (busy),
        .done   (done),
        .win    (win)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Results of the most recent track() call.
    int         ev_t [3];
    logic [2:0] ev_v [3];
    int         n_ev, done_cnt, done_t, busy_low_t, frz_err, tick_err;
    logic [2:0] rise_en;
    logic       rise_win;

    // Sample once per cycle, logging enable changes, done pulses and illegal reel updates.
    task automatic track(input int budget, input int stop_rel, input bit wiggle);
        logic [2:0] prev_en;
        logic [8:0] prev_out;
        int         last_chg [3];
        int         c;
        n_ev = 0; done_cnt = 0; done_t = -1; busy_low_t = -1; frz_err = 0; tick_err = 0;
        for (int r = 0; r < 3; r++) last_chg[r] = -1;
        prev_en = enable;
        prev_out = out;
        c = 0;
        for (int k = 1; k <= budget; k++) begin
            if (k == stop_rel) stop = 1'b1;
            if (wiggle) begin
                lfsr_in = {3'(c + 2), 3'(c + 1), 3'(c)};
                c++;
            end
            @(negedge clk);
            if (enable !== prev_en) begin
                if (n_ev < 3) begin
                    ev_t[n_ev] = k;
                    ev_v[n_ev] = enable;
                end
                n_ev++;
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_t = k;
            end
            if (busy === 1'b0 && busy_low_t < 0) busy_low_t = k;
            for (int r = 0; r < 3; r++) begin
                if (out[r*3 +: 3] !== prev_out[r*3 +: 3]) begin
                    if (!prev_en[r]) frz_err++;
                    else begin
                        if (last_chg[r] >= 0 && k - last_chg[r] != 4) tick_err++;
                        last_chg[r] = k;
                    end
                end
            end
            prev_en = enable;
            prev_out = out;
        end
    endtask

    // Press start for 4 cycles; records enable and win on the first busy cycle.
    task automatic spin_start(input string name);
        bit seen;
        seen = 1'b0;
        start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 4) start = 1'b1;
            if (busy === 1'b1 && !seen) begin
                seen = 1'b1;
                rise_en = enable;
                rise_win = win;
            end
            if (seen && k >= 4) break;
        end
        start = 1'b1;
        check(name, 32'(seen), 32'd1);
    endtask

    typedef struct {
        logic [8:0] lfsr;
        logic [8:0] exp_out;
        logic       exp_all_eq;
    } vec_t;

    vec_t vecs [5];

    initial begin
        vecs[0] = '{9'o555, 9'o555, 1'b1};
        vecs[1] = '{9'o123, 9'o123, 1'b0};
        vecs[2] = '{9'o777, 9'o777, 1'b1};
        vecs[3] = '{9'o000, 9'o000, 1'b1};
        vecs[4] = '{9'o770, 9'o770, 1'b0};

        // Reset state
        reset = 1'b1;
        cyc(3);
        check("rst_out", 32'(out), 32'd0);
        check("rst_enable", 32'(enable), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_win", 32'(win), 32'd0);
        reset = 1'b0;
        cyc(2);

        // Full spin with lfsr_in changing every cycle from the stop press on
        lfsr_in = 9'o123;
        spin_start("spin_busy");
        check("spin_run_enable", 32'(rise_en), 32'h7);
        cyc(4);
        check("spin_run_enable2", 32'(enable), 32'h7);
        stop = 1'b0;
        track(50, 4, 1'b1);
        check("spin_n_events", 32'(n_ev), 32'd3);
        check("spin_en0", 32'(ev_v[0]), 32'h6);
        check("spin_en1", 32'(ev_v[1]), 32'h4);
        check("spin_en2", 32'(ev_v[2]), 32'h0);
        check("spin_gap01", 32'(ev_t[1] - ev_t[0]), 32'd10);
        check("spin_gap12", 32'(ev_t[2] - ev_t[1]), 32'd10);
        check("spin_done_cnt", 32'(done_cnt), 32'd1);
        check("spin_done_time", 32'(done_t), 32'(ev_t[2]));
        check("spin_busy_fall", 32'(busy_low_t), 32'(ev_t[2]));
        check("hold_frozen", 32'(frz_err), 32'd0);
        check("hold_tick_only", 32'(tick_err), 32'd0);

        // Constant-symbol spins: final display and win flag
        for (int v = 0; v < 5; v++) begin
            lfsr_in = vecs[v].lfsr;
            spin_start($sformatf("vec%0d_busy", v));
            check($sformatf("vec%0d_win_clear", v), 32'(rise_win), 32'd0);
            cyc(3);
            stop = 1'b0;
            track(50, 4, 1'b0);
            check($sformatf("vec%0d_done_cnt", v), 32'(done_cnt), 32'd1);
            check($sformatf("vec%0d_out", v), 32'(out), 32'(vecs[v].exp_out));
            check($sformatf("vec%0d_win", v), 32'(win), 32'(vecs[v].exp_all_eq & WinEn));
        end

        // Start and stop together in IDLE: one RUNNING cycle, then STOPPING
        begin
            bit seen;
            seen = 1'b0;
            lfsr_in = 9'o246;
            start = 1'b0;
            stop = 1'b0;
            for (int k = 1; k <= 12 && !seen; k++) begin
                @(negedge clk);
                if (busy === 1'b1) seen = 1'b1;
            end
            start = 1'b1;
            check("simul_busy", 32'(seen), 32'd1);
            check("simul_enable", 32'(enable), 32'h7);
            track(50, 3, 1'b0);
            check("simul_first_stop", 32'(ev_t[0]), 32'd12);
            check("simul_done_cnt", 32'(done_cnt), 32'd1);
        end

        // Stop alone in IDLE is ignored
        stop = 1'b0;
        cyc(8);
        check("stop_idle_busy", 32'(busy), 32'd0);
        check("stop_idle_enable", 32'(enable), 32'd0);
        stop = 1'b1;
        cyc(4);

        // Reset after the first reel has stopped
        begin
            bit hit;
            int dn;
            int bz;
            hit = 1'b0;
            lfsr_in = 9'o321;
            spin_start("abort_busy");
            cyc(2);
            stop = 1'b0;
            for (int k = 1; k <= 40 && !hit; k++) begin
                @(negedge clk);
                if (enable === 3'b110) hit = 1'b1;
            end
            check("abort_reel0_stopped", 32'(hit), 32'd1);
            reset = 1'b1;
            stop = 1'b1;
            @(negedge clk);
            check("abort_out", 32'(out), 32'd0);
            check("abort_enable", 32'(enable), 32'd0);
            check("abort_busy0", 32'(busy), 32'd0);
            check("abort_done0", 32'(done), 32'd0);
            check("abort_win", 32'(win), 32'd0);
            reset = 1'b0;
            dn = 0;
            bz = 0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (done === 1'b1) dn++;
                if (busy === 1'b1) bz++;
            end
            check("abort_no_done", 32'(dn), 32'd0);
            check("abort_stays_idle", 32'(bz), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/slot_core.md
SLOT_CORE -- requirements
Module: slot_core

Interface
REQ-001 Parameter NUM_REELS, default 3, number of reels (1..8).
REQ-002 Parameter SYM_W, default 3, symbol width in bits per reel.
REQ-003 Parameter TICK_DIV, default 10_000_000, clock cycles per reel update tick.
REQ-004 Parameter DEBOUNCE_CYC, default 5_000_000, clock cycles between button samples.
REQ-005 Parameter STOP_GAP, default 100_000_000, clock cycles between successive reel stops.
REQ-006 clk  input  1  system clock; the only clock in the block; all state changes on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 start  input  1  start button, active-low (0 = pressed).
REQ-009 stop  input  1  stop button, active-low (0 = pressed).
REQ-010 lfsr_in  input  NUM_REELS*SYM_W  random symbols; reel i occupies bits [i*SYM_W +: SYM_W].
REQ-011 out  output  NUM_REELS*SYM_W  displayed symbols, packed the same way as lfsr_in.
REQ-012 enable  output  NUM_REELS  enable[i]=1 while reel i spins.
REQ-013 busy  output  1  high in RUNNING or STOPPING.
REQ-014 done  output  1  one-cycle pulse when the last reel stops.
REQ-015 win  output  1  high when all reels show the same symbol after a spin.

Function
REQ-016 Tick counter: counts 0..TICK_DIV-1 and wraps; a tick is the cycle where the count equals TICK_DIV-1.
REQ-017 Debounce counter: counts 0..DEBOUNCE_CYC-1 and wraps; at terminal count it samples start_flag<=~start and stop_flag<=~stop; flags hold between samples.
REQ-018 FSM states: IDLE, RUNNING, STOPPING, DONE, all registered.
REQ-019 Transitions: IDLE->RUNNING on start_flag; RUNNING->STOPPING on stop_flag; STOPPING->DONE on the cycle enable[NUM_REELS-1] falls; DONE->IDLE unconditionally after 1 cycle.
REQ-020 In IDLE with start_flag and stop_flag both set, start wins; stop is honoured in RUNNING on the next cycle if still set.
REQ-021 stop_flag in IDLE and start_flag in RUNNING, STOPPING or DONE are ignored.
REQ-022 enable is all ones in RUNNING; all zeros in IDLE and DONE.
REQ-023 stop_cnt is cleared on STOPPING entry and increments each STOPPING cycle; its width is $clog2(NUM_REELS*STOP_GAP+1); it saturates and never wraps.
REQ-024 In STOPPING, enable[i] clears on the cycle after stop_cnt reaches (i+1)*STOP_GAP, and stays cleared.
REQ-025 On a tick, out slice i loads lfsr_in slice i only if enable[i]=1; stopped reels hold their value.
REQ-026 busy = (state==RUNNING || state==STOPPING), registered-equivalent with no combinational path from inputs.
REQ-027 done is high exactly in the DONE state.
REQ-028 win is evaluated in DONE: it is set if every out slice equals slice 0; it holds until the next RUNNING entry, which clears it.
REQ-029 With NUM_REELS=1, win sets on every completed spin.

Reset
REQ-030 reset high forces all of the following on the next clk edge: state=IDLE, out=0, enable=0, busy=0, done=0, win=0, tick/debounce/stop counters=0, flags=0.
REQ-031 reset asserted mid-spin aborts immediately with no done pulse; operation resumes only on a fresh start_flag.

Configuration
REQ-032 SLOT_WIN_DETECT_EN defined: win is produced per REQ-028.
REQ-033 SLOT_WIN_DETECT_EN undefined: win is tied to 0, no comparator is built, and all other behaviour is unchanged.

Structure
REQ-034 Package slot_pkg holds the state enum (IDLE, RUNNING, STOPPING, DONE) and the default parameter constants.
REQ-035 Sub-module slot_debounce (one instance, two buttons) implements REQ-017; tick, FSM, reels and win logic stay in slot_core.

Verification (NUM_REELS=3, SYM_W=3, TICK_DIV=4, DEBOUNCE_CYC=2, STOP_GAP=10)
REQ-036 Reset: reset high 3 cycles -> out=0, enable=0, busy=0, done=0, win=0.
REQ-037 Spin: start low 4 cycles then stop low 4 cycles -> enable=3'b111 while running; in STOPPING enable clears bit 0, then bit 1, then bit 2, each 10 cycles apart; done pulses once, 1 cycle.
REQ-038 Hold: lfsr_in changed every cycle during STOPPING -> each stopped reel's out slice stays frozen; running reels update only on ticks.
REQ-039 Win: lfsr_in=9'o555 constant -> after done, out=9'o555 and win=1; next start clears win when RUNNING is entered.
REQ-040 Simultaneous: start and stop low together in IDLE -> RUNNING first, then STOPPING; stop low in IDLE alone -> stays IDLE.
REQ-041 Abort: reset pulsed while 1 reel is stopped -> all outputs return to 0 and no done pulse occurs.
